// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter/sequencer sharing one gated S-R latch among NREQ requesters.
// Latency: request sampled at edge 0 -> gnt in cycle 2+PULSE_W+HOLD_W; one op per 3+PULSE_W+HOLD_W cycles.
// Backpressure: requests are levels held until gnt; losers simply wait. Optional macro: SR_VERIFY_EN (readback check).
module sr_latch_arbiter #(
    parameter int NREQ    = 4,
    parameter int PULSE_W = 2,
    parameter int HOLD_W  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_set,
    input  logic [NREQ-1:0] req_clr,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            lat_s,
    output logic            lat_r,
    output logic            lat_en,
    input  logic            lat_q,
    output logic            q_snap,
    output logic            err
);

    localparam int PW   = $clog2(NREQ);
    // One counter serves both PULSE and HOLD, so it must fit the larger of the two.
    localparam int CMAX = (PULSE_W > HOLD_W) ? PULSE_W : HOLD_W;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'((HOLD_W > 0) ? (HOLD_W - 1) : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic            op_set_q, op_set_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            q_snap_q;

    logic [NREQ-1:0] active;
    logic            found;
    logic [PW-1:0]   pick;
    logic            drive;

    assign active = req_set | req_clr;

    // Round-robin search starting at ptr; first active requester wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && active[(int'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // Sequencer next state: capture winner, then setup / pulse / hold / done.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        op_set_d = op_set_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d    = pick;
                    // Clear wins when both set and clear are requested.
                    op_set_d = ~req_clr[pick];
                    ptr_d    = PW'((int'(pick) + 1) % NREQ);
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = PULSE_LD;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_LD;
                    state_d = (HOLD_W == 0) ? S_DONE : S_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation and restarts arbitration at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            op_set_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            op_set_q <= op_set_d;
            cnt_q    <= cnt_d;
        end
    end

    // Capture the latch readback at completion of each operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_snap_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            q_snap_q <= lat_q;
        end
    end

    // Latch drive decoded straight from state so async reset drops it at once;
    // s and r are complementary only while driving, so they are never both high.
    assign drive  = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD);
    assign lat_s  = drive & op_set_q;
    assign lat_r  = drive & ~op_set_q;
    assign lat_en = (state_q == S_PULSE);
    assign busy   = (state_q != S_IDLE);
    assign q_snap = q_snap_q;

    // One-hot grant pulse to the captured winner during DONE.
    always_comb begin
        gnt = '0;
        if (state_q == S_DONE) begin
            gnt[win_q] = 1'b1;
        end
    end

`ifdef SR_VERIFY_EN
    logic err_q;

    // Sticky readback mismatch: latch must read 1 after a set, 0 after a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == S_DONE) && (lat_q != op_set_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_arbiter.sv
module tb_sr_latch_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_set;
    logic [3:0] req_clr;
    logic [3:0] gnt;
    logic       busy;
    logic       lat_s;
    logic       lat_r;
    logic       lat_en;
    logic       lat_q;
    logic       q_snap;
    logic       err;

    logic       latch_q;
    logic       force0;

    int n_chk;
    int n_pass;

`ifdef SR_VERIFY_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    sr_latch_arbiter #(.NREQ(4), .PULSE_W(2), .HOLD_W(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_set (req_set),
        .req_clr (req_clr),
        .gnt     (gnt),
        .busy    (busy),
        .lat_s   (lat_s),
        .lat_r   (lat_r),
        .lat_en  (lat_en),
        .lat_q   (lat_q),
        .q_snap  (q_snap),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple model of the gated S-R latch, with a stuck-at-0 override.
    initial latch_q = 1'b0;
    always @(posedge clk) begin
        if (lat_en) begin
            if (lat_s) latch_q <= 1'b1;
            else if (lat_r) latch_q <= 1'b0;
        end
    end
    assign lat_q = force0 ? 1'b0 : latch_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Wait for the next grant (bounded) and check its cycle distance and value.
    task automatic wait_gnt(input string tag, input logic [3:0] exp_g, input int exp_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0 && n < 40);
        chk({tag, "_cyc"}, n, exp_cyc);
        chk({tag, "_gnt"}, {28'b0, gnt}, {28'b0, exp_g});
    endtask

    // Invariants checked every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_s_and_r", {31'b0, lat_s & lat_r}, 32'd0);
            chk("inv_gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'd1);
        end
    end

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        req_set = 4'b0;
        req_clr = 4'b0;
        force0  = 1'b0;

        // Reset state
        #3;
        chk("reset_outs", {25'b0, gnt, busy, lat_s, lat_r, lat_en}, 32'd0);
        chk("reset_snap_err", {30'b0, q_snap, err}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        @(negedge clk);

        // Single set from requester 0: cycle-by-cycle waveform
        req_set = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("t1_lat_s_c%0d", k), {31'b0, lat_s}, {31'b0, (k >= 1 && k <= 4)});
            chk($sformatf("t1_lat_en_c%0d", k), {31'b0, lat_en}, {31'b0, (k == 2 || k == 3)});
            chk($sformatf("t1_lat_r_c%0d", k), {31'b0, lat_r}, 32'd0);
            chk($sformatf("t1_gnt_c%0d", k), {28'b0, gnt}, (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) req_set = 4'b0;
        end
        chk("t1_q_snap", {31'b0, q_snap}, 32'd1);
        chk("t1_busy_idle", {31'b0, busy}, 32'd0);

        // ptr=1: requester 1 (set) then requester 2 (clear)
        req_set = 4'b0010;
        req_clr = 4'b0100;
        wait_gnt("t2_first", 4'b0010, 5);
        req_set = 4'b0;
        @(negedge clk);
        chk("t2_q_snap_set", {31'b0, q_snap}, 32'd1);
        wait_gnt("t2_second", 4'b0100, 5);
        req_clr = 4'b0;
        @(negedge clk);
        chk("t2_q_snap_clr", {31'b0, q_snap}, 32'd0);

        // All four requesters held from reset
        rst_n   = 1'b0;
        req_set = 4'b1111;
        @(negedge clk);
        chk("t3_in_reset", {25'b0, gnt, busy, lat_s, lat_r, lat_en}, 32'd0);
        rst_n = 1'b1;
        wait_gnt("t3_r0", 4'b0001, 5);
        req_set[0] = 1'b0;
        wait_gnt("t3_r1", 4'b0010, 6);
        req_set[1] = 1'b0;
        wait_gnt("t3_r2", 4'b0100, 6);
        req_set[2] = 1'b0;
        wait_gnt("t3_r3", 4'b1000, 6);
        req_set[3] = 1'b0;
        @(negedge clk);
        chk("t3_q_snap", {31'b0, q_snap}, 32'd1);

        // Set and clear together on requester 3: clear wins
        req_set = 4'b1000;
        req_clr = 4'b1000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t4_lat_s_c%0d", k), {31'b0, lat_s}, 32'd0);
            chk($sformatf("t4_lat_r_c%0d", k), {31'b0, lat_r}, {31'b0, (k >= 1 && k <= 4)});
            chk($sformatf("t4_gnt_c%0d", k), {28'b0, gnt}, (k == 5) ? 32'h8 : 32'd0);
            if (k == 5) begin
                req_set = 4'b0;
                req_clr = 4'b0;
            end
        end
        @(negedge clk);
        chk("t4_q_snap", {31'b0, q_snap}, 32'd0);

        // Reset asserted mid-PULSE with requester 2 held
        req_set = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_pulse", {29'b0, lat_s, lat_r, lat_en}, 32'b101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_drop", {29'b0, lat_s, lat_r, lat_en}, 32'd0);
        @(negedge clk);
        chk("t5_no_gnt", {25'b0, gnt, busy, lat_s, lat_r, lat_en}, 32'd0);
        rst_n = 1'b1;
        wait_gnt("t5_reserve", 4'b0100, 5);
        req_set = 4'b0;
        @(negedge clk);

        // Set with latch stuck at 0: err only with readback check built
        force0  = 1'b1;
        req_set = 4'b0001;
        wait_gnt("t6_set", 4'b0001, 5);
        chk("t6_err_in_done", {31'b0, err}, 32'd0);
        req_set = 4'b0;
        @(negedge clk);
        force0 = 1'b0;
        chk("t6_q_snap", {31'b0, q_snap}, 32'd0);
        chk("t6_err_after", {31'b0, err}, {31'b0, ERR_EXP});
        req_clr = 4'b0010;
        wait_gnt("t6_clr", 4'b0010, 5);
        req_clr = 4'b0;
        @(negedge clk);
        chk("t6_err_sticky", {31'b0, err}, {31'b0, ERR_EXP});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
